// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: shared 1 ms prescaler, per-channel stability counters, press/release strobes.
// Optional long-press detection (hold/held) is built when DEBOUNCE_MULTI_HOLD_EN is defined.
module debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter bit ACTIVE_LOW  = 1'b0,
    parameter int HOLD_MS     = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] held,
    output logic                any_pressed
);

    localparam int P  = CLK_HZ / 1000;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    localparam logic [CHANNELS-1:0] IDLE    = {CHANNELS{ACTIVE_LOW}};
    localparam logic [PW-1:0]       P_LAST  = PW'(P - 1);
    localparam logic [CW-1:0]       DB_LAST = CW'(DEBOUNCE_MS - 1);

    if ((CHANNELS < 1) || (DEBOUNCE_MS < 1) || (HOLD_MS < 1) ||
        (CLK_HZ < 1000) || ((CLK_HZ % 1000) != 0)) begin : g_bad_params
        $error("debounce_multi: invalid parameter set");
    end

    logic [PW-1:0]       pcnt_q;
    logic [PW-1:0]       pcnt_d;
    logic                tick_s;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] s_s;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] fall_d;

    assign tick_s = (pcnt_q == P_LAST);
    assign s_s    = sync2_q ^ IDLE;

    // Prescaler next state: free-running 0..P-1
    always_comb begin
        pcnt_d = pcnt_q;
        if (tick_s) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // Two-flop synchroniser, resets to the idle pin level so release never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel stability counters: any return to the current level restarts the count
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_s && (cnt_q[i] == DB_LAST)) begin
                level_d[i] = s_s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s_s[i];
                fall_d[i]  = ~s_s[i];
            end else if (tick_s) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Prescaler, counters, debounced level and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pcnt_q  <= pcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef DEBOUNCE_MULTI_HOLD_EN
    localparam int          HW       = $clog2(HOLD_MS + 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_MS);

    logic [HW-1:0]       hcnt_q [CHANNELS];
    logic [HW-1:0]       hcnt_d [CHANNELS];
    logic [CHANNELS-1:0] hold_q;
    logic [CHANNELS-1:0] hold_d;
    logic [CHANNELS-1:0] held_q;
    logic [CHANNELS-1:0] held_d;

    // Long-press counters; a release on the threshold tick wins, so held never outlives level
    always_comb begin
        hcnt_d = hcnt_q;
        hold_d = '0;
        held_d = held_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!level_q[i] || fall_d[i]) begin
                hcnt_d[i] = '0;
                held_d[i] = 1'b0;
            end else if (tick_s && (hcnt_q[i] == H_LAST)) begin
                hcnt_d[i] = H_MAX;
                hold_d[i] = 1'b1;
                held_d[i] = 1'b1;
            end else if (tick_s && (hcnt_q[i] != H_MAX)) begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
            end else begin
                hcnt_d[i] = hcnt_q[i];
            end
        end
    end

    // Long-press state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            held_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt_q[i] <= '0;
            end
        end else begin
            hold_q <= hold_d;
            held_q <= held_d;
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign hold = hold_q;
    assign held = held_q;
`else
    assign hold = {CHANNELS{1'b0}};
    assign held = {CHANNELS{1'b0}};
`endif

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign any_pressed = |level_q;

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- N-channel debouncer for push-buttons and switches.
- One shared millisecond prescaler drives per-channel stability counters, so the area cost per channel is small.
- Each channel delivers a debounced level plus single-cycle press/release strobes. Optional long-press detection.
- Sits between the board I/O pins and the control logic, in place of per-pin debounce plus separate edge detectors.

Parameters:
- CHANNELS, 4: number of independent inputs, >=1.
- CLK_HZ, 100_000_000: clk frequency in Hz; must be a multiple of 1000.
- DEBOUNCE_MS, 20: ms ticks of continuous disagreement required to accept a new level, >=1.
- ACTIVE_LOW, 0: 1 = raw pins idle high and read pressed when low; inverted after synchronisation.
- HOLD_MS, 1000: ms ticks a channel must stay pressed before the hold pulse fires (HOLD_EN only), >=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  CHANNELS  raw asynchronous pin inputs.
- level  out  CHANNELS  debounced pressed state (1 = pressed).
- rise  out  CHANNELS  1-cycle strobe on accepted press.
- fall  out  CHANNELS  1-cycle strobe on accepted release.
- hold  out  CHANNELS  1-cycle strobe at long-press threshold.
- held  out  CHANNELS  high from hold strobe until release.
- any_pressed  out  1  OR of level.

Behaviour:
- Reset (rst_n low, async): all state and outputs go to 0, except the sync flops, which load the idle pin value (ACTIVE_LOW). No spurious press is seen after reset release.
- Prescaler (P = CLK_HZ/1000):
  - Counter runs 0..P-1, wrapping to 0.
  - tick is asserted for one cycle when counter == P-1.
  - Clears on reset, so the first tick occurs P cycles after reset release.
- Sync: each channel uses a 2-flop synchroniser. s[i] = sync2[i] XOR ACTIVE_LOW.
- Per-channel counter cnt, width clog2(DEBOUNCE_MS+1). Each cycle:
  - If s == level: cnt <= 0 (any bounce back to the current level restarts the count).
  - Else if tick and cnt == DEBOUNCE_MS-1: level <= s, cnt <= 0, and on the same edge rise <= s, fall <= ~s.
  - Else if tick: cnt <= cnt+1.
  - Otherwise hold.
- rise and fall are registered strobes, high exactly one cycle and coincident with the first cycle of the new level. They are never both high on a channel.
- Latency from a clean pin edge to level change: 2 sync cycles plus between (DEBOUNCE_MS-1)*P+1 and DEBOUNCE_MS*P cycles, depending on prescaler phase.
- Channels are fully independent. Any number may change on the same tick.
- any_pressed is combinational OR of registered level, with no extra latency.
- Mid-operation reset: counters and levels clear immediately. A pin held pressed through reset is re-accepted after the full debounce time, producing a rise.
- Glitches shorter than one tick period are rejected unless they span a tick and persist DEBOUNCE_MS ticks.

Optional Feature:
- Macro: DEBOUNCE_MULTI_HOLD_EN.
- Defined:
  - Each channel has a hold counter, width clog2(HOLD_MS+1). It clears while level == 0 and increments on tick while level == 1, saturating at HOLD_MS.
  - On the tick where the counter reaches HOLD_MS: hold strobes for one cycle and held <= 1.
  - held clears on the same edge that level falls (the fall strobe cycle).
  - At most one hold strobe per press.
- Undefined: no hold counters are built; hold and held are tied to 0. The ports remain so integration is unchanged.

Test Plan (CLK_HZ=10_000 so P=10, DEBOUNCE_MS=3, HOLD_MS=10, CHANNELS=4, ACTIVE_LOW=0):
- Release rst_n with in=0 and run 200 cycles -> level=0, no rise/fall/hold, any_pressed=0. With ACTIVE_LOW=1 and in=4'hF, same result.
- Clean step in[0] 0->1, held -> level[0] rises 23..32 cycles after the step, rise[0] high exactly 1 cycle, any_pressed=1; later release -> fall[0] single pulse.
- Bounce in[1]: 1 for 15 cycles, 0 for 5, then steady 1 -> no rise until 3 full ticks after the final transition; exactly one rise[1].
- Step in[2] and in[3] on the same cycle -> both rise strobes on the same cycle; channels 0/1 unaffected.
- With DEBOUNCE_MULTI_HOLD_EN, hold in[0] pressed for 150 cycles -> hold[0] one pulse 10 ticks after rise[0], held[0]=1 until the fall[0] cycle, then 0. Without the macro, hold/held stay 0.
- Assert rst_n low mid-count with in[0]=1 -> level/cnt clear at once; after release, rise[0] appears again after the full debounce time.
